// File: rtl/hl_loader_pkg.sv
// Shared definitions for the high/low byte loader: FSM state encoding,
// default byte width and the saturating counter helper.
package hl_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_HIGH   = 2'd1,
    S_COMMIT = 2'd2,
    S_FLUSH  = 2'd3
  } hl_state_t;

  // Increment v by one, holding at max_v once reached (counter widths up to 32 bits).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hl_parity_chk.sv
// Odd-parity checker: ok is high when data plus the parity bit hold an odd
// number of ones.
module hl_parity_chk #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  input  logic         par,
  output logic         ok
);

  assign ok = ^{data, par};

endmodule

// File: rtl/hl_byte_loader.sv
// Byte-pair loader feeding a 16-bit high/low load register. Pairs bytes
// low-then-high over a valid/ready handshake and commits each word with a
// single atomic loadh/loadl pulse; flush discards a partial word and clears
// the downstream register. Optional build macro HL_LOADER_PARITY_EN adds a
// per-byte odd-parity check that suppresses the load of a corrupted word.
module hl_byte_loader
  import hl_loader_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [N/2-1:0]   in_data,
  input  logic             in_valid,
`ifdef HL_LOADER_PARITY_EN
  input  logic             in_parity,
  output logic             parity_err,
`endif
  output logic             in_ready,
  input  logic             flush,
  output logic [N/2-1:0]   inh,
  output logic [N/2-1:0]   inl,
  output logic             loadh,
  output logic             loadl,
  output logic             reg_clear,
  output logic             word_done,
  output logic [CNT_W-1:0] words_loaded
);

  localparam int BW = N / 2;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  hl_state_t        state_q, state_d;
  logic [BW-1:0]    lo_q;
  logic             accept;
  logic             word_ok;
  logic             load_d;
  logic             clr_d;
  logic [BW-1:0]    inh_d, inl_d;
  logic [CNT_W-1:0] words_d;

  // Flush has priority over a pending byte, so ready drops while flush is high.
  assign in_ready = ((state_q == S_LOW) || (state_q == S_HIGH)) && !flush;
  assign accept   = in_valid && in_ready;

`ifdef HL_LOADER_PARITY_EN
  logic byte_ok;
  logic lo_ok_q;
  logic perr_d;

  hl_parity_chk #(.W(BW)) u_parity_chk (
    .data (in_data),
    .par  (in_parity),
    .ok   (byte_ok)
  );

  // A word is good only if the stored low byte and the arriving high byte both check.
  assign word_ok = lo_ok_q && byte_ok;
`else
  assign word_ok = 1'b1;
`endif

  // Next state plus next values for the registered register-side outputs.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    clr_d   = 1'b0;
    inh_d   = inh;
    inl_d   = inl;
    words_d = words_loaded;
`ifdef HL_LOADER_PARITY_EN
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_LOW: begin
        if (flush) begin
          state_d = S_FLUSH;
          clr_d   = 1'b1;
        end else if (accept) begin
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (flush) begin
          state_d = S_FLUSH;
          clr_d   = 1'b1;
        end else if (accept) begin
          state_d = S_COMMIT;
          if (word_ok) begin
            load_d  = 1'b1;
            inh_d   = in_data;
            inl_d   = lo_q;
            words_d = CNT_W'(sat_inc(32'(words_loaded), CNT_MAX));
          end
`ifdef HL_LOADER_PARITY_EN
          else begin
            perr_d = 1'b1;
          end
`endif
        end
      end
      // The load is already on the pins this cycle; a flush here is deferred, not lost.
      S_COMMIT: begin
        if (flush) begin
          state_d = S_FLUSH;
          clr_d   = 1'b1;
        end else begin
          state_d = S_LOW;
        end
      end
      // Flush during the clear cycle is absorbed so clears never run back to back.
      S_FLUSH: state_d = S_LOW;
      default: state_d = S_LOW;
    endcase
  end

  // State and registered outputs; clear returns everything to idle without a reg_clear pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= S_LOW;
      loadh        <= 1'b0;
      loadl        <= 1'b0;
      word_done    <= 1'b0;
      reg_clear    <= 1'b0;
      inh          <= '0;
      inl          <= '0;
      words_loaded <= '0;
`ifdef HL_LOADER_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      loadh        <= load_d;
      loadl        <= load_d;
      word_done    <= load_d;
      reg_clear    <= clr_d;
      inh          <= inh_d;
      inl          <= inl_d;
      words_loaded <= words_d;
`ifdef HL_LOADER_PARITY_EN
      parity_err   <= perr_d;
`endif
    end
  end

  // Low-byte holding register; state alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if ((state_q == S_LOW) && accept) begin
      lo_q <= in_data;
`ifdef HL_LOADER_PARITY_EN
      lo_ok_q <= byte_ok;
`endif
    end
  end

endmodule

// File: tb/tb_hl_byte_loader.sv
// Directed bench for hl_byte_loader (N=16, CNT_W=2): a per-cycle vector
// table followed by gapped-handshake and flush-recovery sequences.
module tb_hl_byte_loader;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [7:0] inh, inl;
  logic       loadh, loadl, reg_clear, word_done;
  logic [1:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hl_byte_loader #(.N(16), .CNT_W(2)) dut (
    .clk          (clk),
    .clear        (clear),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .inh          (inh),
    .inl          (inl),
    .loadh        (loadh),
    .loadl        (loadl),
    .reg_clear    (reg_clear),
    .word_done    (word_done),
    .words_loaded (words_loaded)
  );

  typedef struct {
    logic       clr, fl, v;
    logic [7:0] d;
    logic       chk, rdy, ld;
    logic [7:0] inh, inl;
    logic       wd, rc;
    logic [1:0] cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  task automatic row(input int i, input logic clr, fl, v, input logic [7:0] d,
                     input logic chk, rdy, ld, input logic [7:0] eh, el,
                     input logic wd, rc, input logic [1:0] cnt);
    tbl[i] = '{clr, fl, v, d, chk, rdy, ld, eh, el, wd, rc, cnt};
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int n;
    //   i  clr fl v  data   chk rdy ld inh    inl    wd rc cnt
    row( 0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    row( 1, 0, 0, 1, 8'h34, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    row( 2, 0, 0, 1, 8'h12, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    row( 3, 0, 0, 0, 8'h00, 1, 0, 1, 8'h12, 8'h34, 1, 0, 1);
    row( 4, 0, 0, 1, 8'hAA, 1, 1, 0, 8'h12, 8'h34, 0, 0, 1);
    row( 5, 0, 1, 0, 8'h00, 1, 0, 0, 8'h12, 8'h34, 0, 0, 1);
    row( 6, 0, 0, 1, 8'h01, 1, 0, 0, 8'h12, 8'h34, 0, 1, 1);
    row( 7, 0, 0, 1, 8'h01, 1, 1, 0, 8'h12, 8'h34, 0, 0, 1);
    row( 8, 0, 0, 1, 8'h02, 1, 1, 0, 8'h12, 8'h34, 0, 0, 1);
    row( 9, 0, 0, 0, 8'h00, 1, 0, 1, 8'h02, 8'h01, 1, 0, 2);
    row(10, 0, 1, 1, 8'h55, 1, 0, 0, 8'h02, 8'h01, 0, 0, 2);
    row(11, 0, 0, 1, 8'h55, 1, 0, 0, 8'h02, 8'h01, 0, 1, 2);
    row(12, 0, 0, 1, 8'h55, 1, 1, 0, 8'h02, 8'h01, 0, 0, 2);
    row(13, 0, 0, 1, 8'h66, 1, 1, 0, 8'h02, 8'h01, 0, 0, 2);
    row(14, 0, 1, 0, 8'h00, 1, 0, 1, 8'h66, 8'h55, 1, 0, 3);
    row(15, 0, 0, 1, 8'h77, 1, 0, 0, 8'h66, 8'h55, 0, 1, 3);
    row(16, 0, 0, 1, 8'h77, 1, 1, 0, 8'h66, 8'h55, 0, 0, 3);
    row(17, 0, 0, 1, 8'h88, 1, 1, 0, 8'h66, 8'h55, 0, 0, 3);
    row(18, 0, 0, 1, 8'h99, 1, 0, 1, 8'h88, 8'h77, 1, 0, 3);
    row(19, 0, 0, 1, 8'h99, 1, 1, 0, 8'h88, 8'h77, 0, 0, 3);
    row(20, 0, 0, 1, 8'hAB, 1, 1, 0, 8'h88, 8'h77, 0, 0, 3);
    row(21, 0, 0, 0, 8'h00, 1, 0, 1, 8'hAB, 8'h99, 1, 0, 3);
    row(22, 0, 0, 1, 8'hC3, 1, 1, 0, 8'hAB, 8'h99, 0, 0, 3);
    row(23, 1, 0, 0, 8'h00, 1, 1, 0, 8'hAB, 8'h99, 0, 0, 3);
    row(24, 0, 0, 1, 8'h5A, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    row(25, 0, 0, 1, 8'hA5, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    row(26, 0, 0, 0, 8'h00, 1, 0, 1, 8'hA5, 8'h5A, 1, 0, 1);
    row(27, 0, 1, 0, 8'h00, 1, 0, 0, 8'hA5, 8'h5A, 0, 0, 1);
    row(28, 0, 1, 0, 8'h00, 1, 0, 0, 8'hA5, 8'h5A, 0, 1, 1);
    row(29, 0, 0, 0, 8'h00, 1, 1, 0, 8'hA5, 8'h5A, 0, 0, 1);

    // Each row: drive inputs just after an edge, then compare what is visible in that cycle.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      clear    = tbl[i].clr;
      flush    = tbl[i].fl;
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      #1;
      if (tbl[i].chk) begin
        check("in_ready",     i, in_ready,     tbl[i].rdy);
        check("loadh",        i, loadh,        tbl[i].ld);
        check("loadl",        i, loadl,        tbl[i].ld);
        check("inh",          i, inh,          tbl[i].inh);
        check("inl",          i, inl,          tbl[i].inl);
        check("word_done",    i, word_done,    tbl[i].wd);
        check("reg_clear",    i, reg_clear,    tbl[i].rc);
        check("words_loaded", i, words_loaded, tbl[i].cnt);
      end
    end

    // Gapped handshake: low byte, two idle cycles, high byte; load must follow the high accept by one cycle.
    @(posedge clk);
    #1 clear = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    #1 check("gap_lo_ready", 100, in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 check("gap_idle_load", 101, loadh, 1'b0);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1; in_data = 8'h22;
    #1 check("gap_hi_ready", 102, in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1;
    check("gap_loadh",     103, loadh,        1'b1);
    check("gap_loadl",     103, loadl,        1'b1);
    check("gap_inh",       103, inh,          8'h22);
    check("gap_inl",       103, inl,          8'h11);
    check("gap_word_done", 103, word_done,    1'b1);
    check("gap_count",     103, words_loaded, 2'd2);

    // Flush from S_LOW: in_ready must come back exactly two cycles after the flush cycle.
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    #1 check("flush_clear_pulse", 104, reg_clear, 1'b1);
    n = 1;
    while (!in_ready && n < 4) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("flush_recover_ready",  105, in_ready, 1'b1);
    check("flush_recover_cycles", 105, n, 2);
    check("flush_keeps_count",    105, words_loaded, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
